// File: rtl/sdu_uart_pkg.sv
// Shared definitions for the SDU serial link (transmit and receive paths).
package sdu_uart_pkg;

    // Line-side framing state, common to both directions of the link.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // 8N1: one start bit, eight data bits, one stop bit.
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/sdu_byte_fifo.sv
// Synchronous byte FIFO with occupancy count; head byte is visible combinationally.
module sdu_byte_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Pushes into a full FIFO and pops from an empty one are ignored.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two; count tracks net occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is plain data and needs no reset; validity is carried by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sdu_uart_tx.sv
// Buffered 8N1 transmitter: bytes are queued in a FIFO and serialised LSB first on txd.
module sdu_uart_tx
    import sdu_uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     txd,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    uart_state_t   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          baud_last;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;

    sdu_byte_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Not full is the same as count != DEPTH, taken from the registered count.
    assign in_ready  = !fifo_full;
    assign txd       = txd_q;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign baud_last = (baud_q == BAUD_LAST);

    // State, baud counter, bit index, shifter and line register; reset truncates any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    // Next-state logic; a pop loads the shifter and restarts bit timing so that
    // a queued byte follows a stop bit with no idle gap.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_last ? '0 : baud_q + 1'b1;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        txd_d    = 1'b1;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    idx_d    = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                txd_d = 1'b0;
                if (baud_last) state_d = ST_DATA;
            end
            ST_DATA: begin
                txd_d = shift_q[0];
                if (baud_last) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        idx_d    = '0;
                        state_d  = ST_START;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
